// File: rtl/scene_loader_if.sv
// Byte-in / object-write bundle for the scene loader.
// master = loader side, slave = UART/scene-memory side.
interface scene_loader_if #(
  parameter int unsigned OBJ_WIDTH = 673,
  parameter int unsigned ADDR_W    = 6
);
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic [ADDR_W-1:0]    wr_addr;
  logic [OBJ_WIDTH-1:0] wr_data;
  logic                 wr_en;
  // One bit wider than an address so a completely full buffer is representable.
  logic [ADDR_W:0]      num_objs;
  logic                 load_busy;
  logic                 load_done;
  logic                 load_err;

  modport master (
    input  rx_data, rx_valid,
    output wr_addr, wr_data, wr_en, num_objs, load_busy, load_done, load_err
  );

  modport slave (
    output rx_data, rx_valid,
    input  wr_addr, wr_data, wr_en, num_objs, load_busy, load_done, load_err
  );
endinterface

// File: rtl/scene_loader.sv
// Byte-stream scene loader: 0xA5, count N, then N little-endian packed objects to scene memory.
// Optional inter-byte timeout is enabled by defining SCENE_LOADER_TIMEOUT_EN.
module scene_loader #(
  parameter int unsigned OBJ_WIDTH           = 673,
  parameter int unsigned MAX_SCENE_BUF_DEPTH = 64,
  parameter int unsigned TIMEOUT_CYCLES      = 1_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  scene_loader_if.master  bus
);

  localparam int unsigned ADDR_W = $clog2(MAX_SCENE_BUF_DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned BPO    = (OBJ_WIDTH + 7) / 8;
  localparam int unsigned BC_W   = (BPO > 1) ? $clog2(BPO) : 1;
  localparam int unsigned BUF_W  = BPO * 8;

  typedef enum logic [1:0] {StIdle, StCount, StData} state_e;

  // Async assert, sync release of the internal reset.
  logic [1:0] rst_sync_q;
  logic       rst_sync_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_sync_n = rst_sync_q[1];

  state_e               state_q;
  logic [BC_W-1:0]      byte_cnt_q;
  logic [CNT_W-1:0]     obj_cnt_q;
  logic [CNT_W-1:0]     n_q;
  logic [BUF_W-1:0]     buf_q;
  logic [ADDR_W-1:0]    wr_addr_q;
  logic [OBJ_WIDTH-1:0] wr_data_q;
  logic                 wr_en_q;
  logic [CNT_W-1:0]     num_objs_q;
  logic                 load_done_q;
  logic                 load_err_q;

  logic [BUF_W-1:0]     asm_word;
  logic                 n_ok;
  logic                 byte_last;
  logic                 obj_last;

  // Object word with the incoming byte merged at the current byte slot.
  always_comb begin
    asm_word = buf_q;
    for (int k = 0; k < int'(BPO); k++) begin
      if (byte_cnt_q == BC_W'(k)) begin
        asm_word[8*k +: 8] = bus.rx_data;
      end
    end
  end

  assign n_ok      = (bus.rx_data != 8'd0) && (32'(bus.rx_data) <= MAX_SCENE_BUF_DEPTH);
  assign byte_last = (byte_cnt_q == BC_W'(BPO - 1));
  assign obj_last  = (obj_cnt_q == n_q - CNT_W'(1));

`ifdef SCENE_LOADER_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;
`endif

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q     <= StIdle;
      byte_cnt_q  <= '0;
      obj_cnt_q   <= '0;
      n_q         <= '0;
      buf_q       <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      num_objs_q  <= '0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
`ifdef SCENE_LOADER_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      wr_en_q     <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (bus.rx_valid && (bus.rx_data == 8'hA5)) begin
            state_q <= StCount;
          end
        end
        StCount: begin
          if (bus.rx_valid) begin
            if (n_ok) begin
              n_q        <= CNT_W'(bus.rx_data);
              byte_cnt_q <= '0;
              obj_cnt_q  <= '0;
              state_q    <= StData;
            end else begin
              load_err_q <= 1'b1;
              state_q    <= StIdle;
            end
          end
        end
        StData: begin
          // 0xA5 is plain payload here; there is no resync inside a load.
          if (bus.rx_valid) begin
            buf_q <= asm_word;
            if (byte_last) begin
              byte_cnt_q <= '0;
              obj_cnt_q  <= obj_cnt_q + CNT_W'(1);
              wr_en_q    <= 1'b1;
              wr_addr_q  <= obj_cnt_q[ADDR_W-1:0];
              wr_data_q  <= asm_word[OBJ_WIDTH-1:0];
              if (obj_last) begin
                load_done_q <= 1'b1;
                num_objs_q  <= n_q;
                state_q     <= StIdle;
              end
            end else begin
              byte_cnt_q <= byte_cnt_q + BC_W'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase

`ifdef SCENE_LOADER_TIMEOUT_EN
      if (bus.rx_valid || (state_q == StIdle)) begin
        to_cnt_q <= '0;
      end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        to_cnt_q   <= '0;
        load_err_q <= 1'b1;
        state_q    <= StIdle;
      end else begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end
`endif
    end
  end

  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.num_objs  = num_objs_q;
  assign bus.load_done = load_done_q;
  assign bus.load_err  = load_err_q;
  assign bus.load_busy = (state_q != StIdle);

endmodule

// File: tb/tb_scene_loader.sv
// Directed bench for scene_loader: OBJ_WIDTH=20 (3 bytes/object), depth 4, timeout 16.
module tb_scene_loader;

  localparam int unsigned OW     = 20;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 2;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  scene_loader_if #(.OBJ_WIDTH(OW), .ADDR_W(ADDR_W)) bus ();

  scene_loader #(
    .OBJ_WIDTH          (OW),
    .MAX_SCENE_BUF_DEPTH(DEPTH),
    .TIMEOUT_CYCLES     (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write/pulse log, sampled on the falling edge.
  logic [OW-1:0]     wd_log [64];
  logic [ADDR_W-1:0] wa_log [64];
  int   wr_n = 0;
  int   err_n = 0;
  int   done_n = 0;
  int   adj_n = 0;
  logic prev_wr = 1'b0;
  logic [ADDR_W:0] done_num = '0;
  logic done_with_wr = 1'b0;

  always @(negedge clk) begin
    prev_wr <= bus.wr_en;
    if (bus.wr_en) begin
      wd_log[wr_n % 64] <= bus.wr_data;
      wa_log[wr_n % 64] <= bus.wr_addr;
      wr_n <= wr_n + 1;
      if (prev_wr) adj_n <= adj_n + 1;
    end
    if (bus.load_err) err_n <= err_n + 1;
    if (bus.load_done) begin
      done_n       <= done_n + 1;
      done_num     <= bus.num_objs;
      done_with_wr <= bus.wr_en;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
    end
  endtask

  int base_w;
  int base_e;
  int base_d;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    idle(3);

    // Reset state
    chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
    chk("rst_num_objs", 32'(bus.num_objs), 32'd0);
    chk("rst_busy", 32'(bus.load_busy), 32'd0);
    chk("rst_done_err", 32'({bus.load_done, bus.load_err}), 32'd0);
    rst_n = 1'b1;
    idle(3);

    // Two-object load, with a gap after the header byte
    base_w = wr_n;
    base_d = done_n;
    send(8'hA5);
    idle(1);
    chk("busy_in_count", 32'(bus.load_busy), 32'd1);
    send(8'h02); send(8'h11); send(8'h22); send(8'hF3);
    send(8'h44); send(8'h55); send(8'h66);
    idle(3);
    chk("t1_nwr", 32'(wr_n - base_w), 32'd2);
    chk("t1_addr0", 32'(wa_log[base_w]), 32'd0);
    chk("t1_data0", 32'(wd_log[base_w]), 32'h32211);
    chk("t1_addr1", 32'(wa_log[base_w + 1]), 32'd1);
    chk("t1_data1", 32'(wd_log[base_w + 1]), 32'h65544);
    chk("t1_done_n", 32'(done_n - base_d), 32'd1);
    chk("t1_done_num", 32'(done_num), 32'd2);
    chk("t1_done_with_wr", 32'(done_with_wr), 32'd1);
    chk("t1_busy_after", 32'(bus.load_busy), 32'd0);

    // Noise before sync, then out-of-range count
    base_w = wr_n;
    base_e = err_n;
    send(8'h00); send(8'h7E); send(8'hA5); send(8'h05);
    idle(3);
    chk("t2_no_wr", 32'(wr_n - base_w), 32'd0);
    chk("t2_err_once", 32'(err_n - base_e), 32'd1);
    chk("t2_num_kept", 32'(bus.num_objs), 32'd2);
    send(8'hA5); send(8'h01); send(8'hAA); send(8'hBB); send(8'hCC);
    idle(1);
    chk("t2_wr_next_cycle", 32'(bus.wr_en), 32'd1);
    chk("t2_done_same_cycle", 32'(bus.load_done), 32'd1);
    chk("t2_num_same_cycle", 32'(bus.num_objs), 32'd1);
    idle(2);
    chk("t2_addr", 32'(wa_log[base_w]), 32'd0);
    chk("t2_data", 32'(wd_log[base_w]), 32'hCBBAA);
    chk("t2_wr_pulse", 32'(bus.wr_en), 32'd0);

    // Full buffer, back-to-back bytes, 0xA5 inside the payload
    base_w = wr_n;
    send(8'hA5); send(8'h04);
    send(8'hA5);
    for (int i = 2; i <= 12; i++) send(8'(i));
    idle(3);
    chk("t3_nwr", 32'(wr_n - base_w), 32'd4);
    for (int i = 0; i < 4; i++) chk("t3_addr", 32'(wa_log[base_w + i]), 32'(i));
    chk("t3_data0", 32'(wd_log[base_w]), 32'h302A5);
    chk("t3_data1", 32'(wd_log[base_w + 1]), 32'h60504);
    chk("t3_data3", 32'(wd_log[base_w + 3]), 32'hC0B0A);
    chk("t3_no_adjacent", 32'(adj_n), 32'd0);
    chk("t3_num_objs", 32'(bus.num_objs), 32'd4);

    // Reset in the middle of a load
    base_e = err_n;
    send(8'hA5); send(8'h02);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t4_rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("t4_rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("t4_rst_wr_data", 32'(bus.wr_data), 32'd0);
    chk("t4_rst_num", 32'(bus.num_objs), 32'd0);
    chk("t4_rst_busy", 32'(bus.load_busy), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(3);
    chk("t4_no_err", 32'(err_n - base_e), 32'd0);
    base_w = wr_n;
    send(8'hA5); send(8'h01); send(8'hDE); send(8'hAD); send(8'hBE);
    idle(3);
    chk("t4_data", 32'(wd_log[base_w]), 32'hEADDE);
    chk("t4_num_objs", 32'(bus.num_objs), 32'd1);

    // Stall inside a load
    base_e = err_n;
    send(8'hA5); send(8'h02); send(8'h11);
    idle(20);
`ifdef SCENE_LOADER_TIMEOUT_EN
    chk("t5_timeout_err", 32'(err_n - base_e), 32'd1);
    chk("t5_busy", 32'(bus.load_busy), 32'd0);
`else
    chk("t5_no_err", 32'(err_n - base_e), 32'd0);
    chk("t5_busy", 32'(bus.load_busy), 32'd1);
`endif
    chk("t5_num_kept", 32'(bus.num_objs), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
